// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/write-back sequencing.
// Optional feature macro: JUMP_EN (adds the JUMP state and the j opcode).
`timescale 1ns/1ps
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8
`ifdef JUMP_EN
    , S_JUMP    = 4'd9
`endif
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;

    case (state_q)
      // IR and PC update only on the cycle the memory delivers, so a stall never double-writes
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // While reset is held the state already reads FETCH, but no write or read may escape
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcB     = 2'b01;
      ALUop       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expectations from an instruction-path model.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memtoReg;
    logic       irWrite, aluSrcA, regWrite, regDst;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       illegal;
  } snapT;

  snapT  expQ[$];
  string tagQ[$];
  int    checkCount = 0;
  int    failCount  = 0;

  function automatic snapT sampleDut();
    snapT s;
    s.st = state;             s.pcWrite = PCWrite;   s.pcWriteCond = PCWriteCond;
    s.iorD = IorD;            s.memRead = MemRead;   s.memWrite = MemWrite;
    s.memtoReg = MemtoReg;    s.irWrite = IRWrite;   s.aluSrcA = ALUSrcA;
    s.regWrite = RegWrite;    s.regDst = RegDst;     s.aluSrcB = ALUSrcB;
    s.aluOp = ALUop;          s.pcSource = PCSource; s.illegal = illegal_op;
    return s;
  endfunction

  function automatic bit isLegal(logic [5:0] op);
    bit ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100);
`ifdef JUMP_EN
    ok = ok || (op == 6'b000010);
`endif
    return ok;
  endfunction

  // Control values required in a given step, straight from the per-state table
  function automatic snapT expected(int st, bit rdy, logic [5:0] op, logic rst);
    snapT e;
    e = '0;
    if (rst) begin
      e.aluSrcB = 2'b01;
      return e;
    end
    e.st = 4'(st);
    case (st)
      0: begin e.memRead = 1; e.aluSrcB = 2'b01; e.irWrite = rdy; e.pcWrite = rdy; end
      1: begin e.aluSrcB = 2'b11; e.illegal = !isLegal(op); end
      2: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; end
      3: begin e.memRead = 1; e.iorD = 1; end
      4: begin e.regWrite = 1; e.memtoReg = 1; end
      5: begin e.memWrite = 1; e.iorD = 1; end
      6: begin e.aluSrcA = 1; e.aluOp = 2'b10; end
      7: begin e.regWrite = 1; e.regDst = 1; end
      8: begin e.aluSrcA = 1; e.aluOp = 2'b01; e.pcWriteCond = 1; e.pcSource = 2'b01; end
      9: begin e.pcWrite = 1; e.pcSource = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(string tag, snapT got, snapT exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got state=%0d ctl=%h, required state=%0d ctl=%h",
               tag, got.st, got[16:0], exp.st, exp[16:0]);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    snapT  e;
    string t;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(t, sampleDut(), e);
    end
  end

  task automatic driveCycle(string tag, int st, bit rdy, logic [5:0] op);
    opcode    = op;
    mem_ready = rdy;
    expQ.push_back(expected(st, rdy, op, reset));
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Expands one instruction into its state path, inserting the requested memory stalls
  task automatic applyStimulus(logic [5:0] op, int fetchStall, int memStall, string tag);
    int path[$];
    int stalls;
    logic [5:0] stepOp;
    path = {0, 1};
    case (op)
      6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b000000: begin path.push_back(6); path.push_back(7); end
      6'b000100: path.push_back(8);
`ifdef JUMP_EN
      6'b000010: path.push_back(9);
`endif
      default: ;
    endcase
    foreach (path[i]) begin
      stepOp = (path[i] == 0) ? 6'($urandom_range(0, 63)) : op;
      stalls = (path[i] == 0) ? fetchStall : ((path[i] == 3 || path[i] == 5) ? memStall : 0);
      for (int k = 0; k < stalls; k++)
        driveCycle($sformatf("%s/s%0d/stall", tag, path[i]), path[i], 1'b0, stepOp);
      if (path[i] == 0 || path[i] == 3 || path[i] == 5)
        driveCycle($sformatf("%s/s%0d", tag, path[i]), path[i], 1'b1, stepOp);
      else
        driveCycle($sformatf("%s/s%0d", tag, path[i]), path[i], 1'($urandom_range(0, 1)), stepOp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] op;
    int kind;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    driveCycle("resetHeld", 0, 1'b1, 6'b111111);
    reset = 1'b0;

    applyStimulus(6'b100011, 0, 0, "lw");
    applyStimulus(6'b101011, 0, 3, "swStall");
    applyStimulus(6'b000000, 0, 0, "rtype");
    applyStimulus(6'b000100, 0, 0, "beq");
    applyStimulus(6'b000010, 0, 0, "j");
    applyStimulus(6'b111111, 0, 0, "illegal");
    applyStimulus(6'b100011, 2, 2, "lwStall");

    // Asynchronous reset in the middle of EXECUTE
    driveCycle("rstSeq/s0", 0, 1'b1, 6'b000000);
    driveCycle("rstSeq/s1", 1, 1'b1, 6'b000000);
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    expQ.push_back(expected(6, 1'b1, 6'b000000, 1'b0));
    tagQ.push_back("rstSeq/s6");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstAsync", sampleDut(), expected(0, 1'b1, 6'b000000, 1'b1));
    @(posedge clk);
    #1;
    driveCycle("rstHold", 0, 1'b1, 6'b000000);
    reset = 1'b0;
    applyStimulus(6'b000000, 0, 0, "afterRst");

    repeat (40) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (isLegal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      applyStimulus(op, $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%02h", op));
    end

    @(negedge clk);
    #1;
    checkCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back. Each cycle it drives the ALUop code consumed by the ALU control decoder, plus every mux select and write enable in the datapath. Memory accesses are stretched by a ready handshake, so slow memory stalls the sequence without corrupting state.

## Interface
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode (used only with JUMP_EN)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; returns FSM to FETCH
- opcode  input  6  instr[31:26] from instruction register
- mem_ready  input  1  memory has completed current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- ALUSrcB  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUop  output  2  00 add, 01 subtract, 10 decode funct field
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- state  output  4  current state encoding (debug)
- illegal_op  output  1  unsupported opcode seen in DECODE

## Operation
- States/encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9. Codes 10–15 are unreachable and recover to FETCH next cycle with all enables 0.
- Outputs are a pure function of state plus mem_ready gating. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target precompute). Next state by opcode:
  - LW/SW → MEM_ADDR
  - RTYPE → EXECUTE
  - BEQ → BRANCH
  - J → JUMP (JUMP_EN only)
  - anything else → FETCH, with illegal_op=1 for this one cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEM_READ if LW, MEM_WRITE if SW.
- MEM_READ: MemRead=1, IorD=1. Holds while mem_ready=0; goes to MEM_WB when 1.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds while mem_ready=0; goes to FETCH when 1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUop=10 → R_WB.
- R_WB: RegWrite=1, MemtoReg=0, RegDst=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- opcode is sampled only in DECODE and MEM_ADDR. The IR must stay stable until the next FETCH write.

## Timing
- Reset asserted: state=FETCH immediately (asynchronous). All write enables (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite) are forced to 0. MemRead=0 and illegal_op=0. Mux selects take their FETCH values.
- After reset deasserts, the first FETCH is the first clock edge.
- Reset mid-instruction abandons it with no further writes; the next edge acts as a fresh FETCH.
- Cycles with mem_ready held high, counting from entering FETCH to re-entering FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. No enable pulses twice, because IRWrite and PCWrite are gated by mem_ready.
- mem_ready is ignored in every other state.

## Configuration
- JUMP_EN defined: JUMP state exists; OP_J decodes to JUMP; PCSource=10 is reachable.
- JUMP_EN undefined: JUMP state is not built; OP_J is illegal (DECODE → FETCH, illegal_op pulse); PCSource never exceeds 01.

## Test plan
- Reset asserted mid-EXECUTE → state=0 within the same cycle and RegWrite=0. After release, the first edge with mem_ready=1 pulses IRWrite=1 and PCWrite=1.
- opcode=100011 with mem_ready=1 → state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- opcode=101011, mem_ready low for 3 cycles in MEM_WRITE → MemWrite=1 and IorD=1 held for 4 cycles, then return to state 0. No RegWrite at any point.
- opcode=000000 → ALUop=10 in state 6, then RegWrite=1 and RegDst=1 in state 7. Total 4 cycles.
- opcode=000100 → ALUop=01, PCWriteCond=1 and PCSource=01 in state 8, then FETCH.
- opcode=000010 → with JUMP_EN: state 9 with PCWrite=1 and PCSource=10. Without JUMP_EN: illegal_op=1 in DECODE, then FETCH. opcode=111111 → illegal_op pulse in both builds.
